// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Multi-cycle 32x32 unsigned shift-add multiplier (low word)
//               that borrows the shared EX-stage ALU via a req/gnt handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [3:0]       c_ctrl_add = 4'b0010;
    localparam logic [3:0]       c_ctrl_sll = 4'b0101;
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_SHL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_acc_q, w_acc_d;
    logic [WIDTH-1:0] r_mcand_q, w_mcand_d;
    logic [WIDTH-1:0] r_mplier_q, w_mplier_d;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic [WIDTH-1:0] r_product_q, w_product_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q   <= S_IDLE;
            r_acc_q     <= '0;
            r_mcand_q   <= '0;
            r_mplier_q  <= '0;
            r_cnt_q     <= '0;
            r_product_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_acc_q     <= w_acc_d;
            r_mcand_q   <= w_mcand_d;
            r_mplier_q  <= w_mplier_d;
            r_cnt_q     <= w_cnt_d;
            r_product_q <= w_product_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_acc_d     = r_acc_q;
        w_mcand_d   = r_mcand_q;
        w_mplier_d  = r_mplier_q;
        w_cnt_d     = r_cnt_q;
        w_product_d = r_product_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_acc_d    = '0;
                    w_mcand_d  = op_a;
                    w_mplier_d = op_b;
                    w_cnt_d    = '0;
                    if (op_b == '0) begin
                        w_state_d   = S_DONE;
                        w_product_d = '0;
                    end else if (op_b[0]) begin
                        w_state_d = S_ADD;
                    end else begin
                        w_state_d = S_SHL;
                    end
                end
            end
            S_ADD: begin
                if (alu_gnt) begin
                    w_acc_d   = alu_result;
                    w_state_d = S_SHL;
                end
            end
            S_SHL: begin
                if (alu_gnt) begin
                    w_mcand_d  = alu_result;
                    w_mplier_d = r_mplier_q >> 1;
                    w_cnt_d    = r_cnt_q + CNT_W'(1);
                    // Bit 1 of the old multiplier is bit 0 of the shifted one.
                    if ((r_mplier_q >> 1) == '0 || r_cnt_q == c_cnt_max) begin
                        w_state_d   = S_DONE;
                        w_product_d = r_acc_q;
                    end else if (r_mplier_q[1]) begin
                        w_state_d = S_ADD;
                    end else begin
                        w_state_d = S_SHL;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (r_state_q != S_IDLE);
        done     = (r_state_q == S_DONE);
        product  = r_product_q;
        alu_req  = 1'b0;
        alu_ctrl = 4'b0000;
        alu_a    = '0;
        alu_b    = '0;
        case (r_state_q)
            S_ADD: begin
                alu_req  = 1'b1;
                alu_ctrl = c_ctrl_add;
                alu_a    = r_acc_q;
                alu_b    = r_mcand_q;
            end
            S_SHL: begin
                alu_req  = 1'b1;
                alu_ctrl = c_ctrl_sll;
                alu_a    = r_mcand_q;
                alu_b    = WIDTH'(1);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Self-checking bench for mul_seq_ctrl with a behavioural ALU
//               and an arithmetic reference model of product and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        alu_req;
    logic        alu_gnt;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    int n_pass;
    int n_checks;

    mul_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU stand-in: ADD and logical shift-left.
    always_comb begin
        alu_result = 32'd0;
        if (alu_ctrl == 4'b0010)      alu_result = alu_a + alu_b;
        else if (alu_ctrl == 4'b0101) alu_result = alu_a << alu_b[4:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int popcount(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic int msb_index(input logic [31:0] v);
        int m = -1;
        for (int i = 0; i < 32; i++) if (v[i]) m = i;
        return m;
    endfunction

    // gnt_mode: 0 = always granted, 1 = random, 2 = repeating 1,0,0.
    // poke: pulse start with other operands while busy and in DONE.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int gnt_mode, input bit poke, input string tag);
        logic [63:0] full;
        logic [31:0] exp_prod;
        int exp_lat;
        int n_add, n_shl, stalls, cyc, pat;
        bit prev_stall, got_done;
        logic [31:0] sa, sb;
        logic [3:0]  sc;

        full     = 64'(a) * 64'(b);
        exp_prod = full[31:0];
        exp_lat  = (b == 0) ? 1 : 1 + popcount(b) + msb_index(b) + 1;
        n_add = 0; n_shl = 0; stalls = 0; pat = 0;
        prev_stall = 1'b0; got_done = 1'b0;
        sa = '0; sb = '0; sc = '0;

        op_a  = a;
        op_b  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        cyc   = 1;
        while (cyc < 400) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (!busy) check({tag, " busy"}, 32'(busy), 32'd1);
            if (prev_stall) begin
                check({tag, " stall_a"}, alu_a, sa);
                check({tag, " stall_b"}, alu_b, sb);
                check({tag, " stall_ctrl"}, 32'(alu_ctrl), 32'(sc));
            end
            if (!alu_req && (alu_ctrl !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0))
                check({tag, " idle_alu"}, {alu_ctrl, alu_a[27:0]}, 32'd0);
            case (gnt_mode)
                0:       alu_gnt = 1'b1;
                1:       alu_gnt = 1'($urandom_range(0, 1));
                default: alu_gnt = (pat % 3 == 0);
            endcase
            pat++;
            if (poke) begin
                start = (cyc == 2);
                op_a  = 32'hDEAD_BEEF;
                op_b  = 32'h0000_00FF;
            end
            prev_stall = 1'b0;
            if (alu_req && alu_gnt) begin
                if (alu_ctrl == 4'b0010) n_add++;
                else n_shl++;
            end else if (alu_req) begin
                stalls++;
                prev_stall = 1'b1;
                sa = alu_a; sb = alu_b; sc = alu_ctrl;
            end
            step();
            cyc++;
        end
        alu_gnt = 1'b1;
        if (!got_done) begin
            check({tag, " timeout"}, 32'(cyc), 32'(exp_lat + stalls));
            return;
        end
        check({tag, " product"}, product, exp_prod);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat + stalls));
        check({tag, " adds"}, 32'(n_add), 32'(popcount(b)));
        check({tag, " shls"}, 32'(n_shl), 32'(msb_index(b) + 1));
        if (poke) begin
            start = 1'b1;
            op_a  = 32'd2;
            op_b  = 32'd2;
        end
        step();
        start = 1'b0;
        check({tag, " done_pulse"}, {30'd0, busy, done}, 32'd0);
        check({tag, " product_hold"}, product, exp_prod);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int mode;
        n_pass = 0; n_checks = 0;
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; alu_gnt = 1'b1;
        step(); step();
        check("reset busy_done_req", {29'd0, busy, done, alu_req}, 32'd0);
        check("reset product", product, 32'd0);
        check("reset alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        rst_n = 1'b1;
        step();

        run_mul(32'd6, 32'd7, 0, 1'b0, "mul6x7");
        run_mul(32'h1234, 32'd0, 0, 1'b0, "opb_zero");
        run_mul(32'hFFFF_FFFF, 32'd2, 0, 1'b0, "wrap");
        run_mul(32'd3, 32'h8000_0000, 0, 1'b0, "msb_only");
        run_mul(32'd5, 32'd3, 2, 1'b0, "gnt_stall");
        run_mul(32'd11, 32'd13, 0, 1'b1, "busy_start");
        run_mul(32'd2, 32'd2, 0, 1'b0, "after_done_start");

        // Abort mid-operation with a one-cycle reset.
        op_a = 32'h1111; op_b = 32'h0F0F; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort busy_req", {30'd0, busy, alu_req}, 32'd0);
        check("abort product", product, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (done) check("abort no_done", 32'(done), 32'd0);
            step();
        end
        run_mul(32'd9, 32'd9, 0, 1'b0, "post_abort");

        for (int t = 0; t < 20; t++) begin
            ra   = $urandom;
            rb   = $urandom >> $urandom_range(0, 31);
            mode = $urandom_range(0, 2);
            run_mul(ra, rb, mode, 1'b0, "random");
        end
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, "all_ones");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
